// File: rtl/comb_feature_extract.sv
// Glyph comb-line feature extractor: counts 0->1 crossings along three row
// lines and three column lines of a 16x16 raster frame.
module comb_feature_extract #(
  parameter int unsigned L0 = 4,
  parameter int unsigned L1 = 8,
  parameter int unsigned L2 = 12
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        PIX,
  input  logic        PIX_VALID,
  input  logic        SOF,
  output logic [23:0] FEAT,
  output logic        FEAT_VALID,
  output logic        BUSY
);

  localparam int unsigned CW = 4;
  localparam int unsigned NL = 3;
  localparam int unsigned FW = 2 * NL * CW;
  localparam logic [NL*CW-1:0] LINES = {CW'(L2), CW'(L1), CW'(L0)};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   row, col, row_next, col_next;
  logic [CW-1:0]   row_cnt [NL];
  logic [CW-1:0]   col_cnt [NL];
  logic [CW-1:0]   row_cnt_next [NL];
  logic [CW-1:0]   col_cnt_next [NL];
  logic [NL-1:0]   col_hist, col_hist_next;
  logic            prev_pix, prev_pix_next;
  logic [FW-1:0]   feat_next;
  logic            feat_valid_next, busy_next;
  logic            start, take, last;
  logic [CW-1:0]   r, c;

  // Next-state, working-counter update and output staging
  always_comb begin
    state_next      = state;
    row_next        = row;
    col_next        = col;
    row_cnt_next    = row_cnt;
    col_cnt_next    = col_cnt;
    col_hist_next   = col_hist;
    prev_pix_next   = prev_pix;
    feat_next       = FEAT;
    feat_valid_next = 1'b0;

    // An accepted SOF always restarts at (0,0) with cleared counts
    start = PIX_VALID & SOF;
    take  = PIX_VALID & (start | (state == SCAN));
    r     = start ? '0 : row;
    c     = start ? '0 : col;
    last  = take & (&r) & (&c);

    if (start) begin
      for (int k = 0; k < NL; k++) begin
        row_cnt_next[k] = '0;
        col_cnt_next[k] = '0;
      end
      col_hist_next = '0;
    end

    if (take) begin
      prev_pix_next = PIX;
      col_next      = c + CW'(1);
      row_next      = (&c) ? r + CW'(1) : r;
      for (int k = 0; k < NL; k++) begin
        if ((r == LINES[k*CW +: CW]) && PIX && !((c != '0) && prev_pix))
          row_cnt_next[k] = row_cnt_next[k] + CW'(1);
        if (c == LINES[k*CW +: CW]) begin
          if (PIX && !((r != '0) && col_hist[k]))
            col_cnt_next[k] = col_cnt_next[k] + CW'(1);
          col_hist_next[k] = PIX;
        end
      end
    end

    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last) state_next = DONE;
      DONE:    state_next = start ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase

    // Result is published as the FSM enters DONE
    if (last) begin
      feat_next = {col_cnt_next[2], col_cnt_next[1], col_cnt_next[0],
                   row_cnt_next[2], row_cnt_next[1], row_cnt_next[0]};
      feat_valid_next = 1'b1;
    end

    busy_next = (state_next == SCAN);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      col_hist   <= '0;
      prev_pix   <= 1'b0;
      FEAT       <= '0;
      FEAT_VALID <= 1'b0;
      BUSY       <= 1'b0;
      for (int k = 0; k < NL; k++) begin
        row_cnt[k] <= '0;
        col_cnt[k] <= '0;
      end
    end else begin
      state      <= state_next;
      row        <= row_next;
      col        <= col_next;
      col_hist   <= col_hist_next;
      prev_pix   <= prev_pix_next;
      FEAT       <= feat_next;
      FEAT_VALID <= feat_valid_next;
      BUSY       <= busy_next;
      for (int k = 0; k < NL; k++) begin
        row_cnt[k] <= row_cnt_next[k];
        col_cnt[k] <= col_cnt_next[k];
      end
    end
  end

endmodule

// File: tb/tb_comb_feature_extract.sv
// Directed self-checking bench for comb_feature_extract.
module tb_comb_feature_extract;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        PIX;
  logic        PIX_VALID;
  logic        SOF;
  logic [23:0] FEAT;
  logic        FEAT_VALID;
  logic        BUSY;

  int errors = 0;
  int checks = 0;
  int fv_count = 0;
  int busy_bad = 0;

  comb_feature_extract dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .PIX       (PIX),
    .PIX_VALID (PIX_VALID),
    .SOF       (SOF),
    .FEAT      (FEAT),
    .FEAT_VALID(FEAT_VALID),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (FEAT_VALID === 1'b1) fv_count++;

  // 0 = all zero, 1 = vertical bar at column 8, 2 = even rows ink, 3 = checkerboard
  function automatic logic pattern(input int kind, input int r, input int c);
    case (kind)
      1:       return (c == 8);
      2:       return (r % 2 == 0);
      3:       return ((r + c) % 2 == 1);
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle on the falling edge, return just after the rising edge
  task automatic px(input logic p, input logic s, input logic v);
    @(negedge CLK);
    PIX = p;
    SOF = s;
    PIX_VALID = v;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) px(1'b0, 1'b0, 1'b0);
  endtask

  // Sends n pixels of a pattern starting with SOF; counts BUSY drops mid-frame
  task automatic send_frame(input int kind, input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          px(1'(~pattern(kind, i / 16, i % 16)), 1'b1, 1'b0);
          if (BUSY !== 1'b1) busy_bad++;
        end
      end
      px(pattern(kind, i / 16, i % 16), (i == 0), 1'b1);
      if (i < 255 && BUSY !== 1'b1) busy_bad++;
    end
  endtask

  task automatic check_frame(input string name, input logic [23:0] exp);
    checks++;
    if (FEAT_VALID !== 1'b1) begin
      errors++;
      $display("FAIL %s_fv: got %b want 1", name, FEAT_VALID);
    end
    checks++;
    if (FEAT !== exp) begin
      errors++;
      $display("FAIL %s_feat: got %h want %h", name, FEAT, exp);
    end
  endtask

  task automatic check_busy_flag(input string name);
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s_busy: got %0d low cycles want 0", name, busy_bad);
    end
    busy_bad = 0;
  endtask

  task automatic test_reset();
    CLR = 1'b1; PIX = 1'b0; PIX_VALID = 1'b0; SOF = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (FEAT !== 24'h0) begin errors++; $display("FAIL reset_feat: got %h want 000000", FEAT); end
    checks++;
    if (FEAT_VALID !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", FEAT_VALID); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 5; i++) px(1'b1, 1'b0, 1'b1);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_ignore_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_zero_frame();
    send_frame(0, 1'b0, 256);
    check_frame("zero", 24'h000000);
    check_busy_flag("zero");
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL zero_done_busy: got %b want 0", BUSY); end
    idle(1);
    checks++;
    if (FEAT_VALID !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: got %b want 0", FEAT_VALID); end
    idle(2);
  endtask

  task automatic test_vbar();
    send_frame(1, 1'b0, 256);
    check_frame("vbar", 24'h010111);
    check_busy_flag("vbar");
    idle(2);
  endtask

  task automatic test_even_rows();
    send_frame(2, 1'b0, 256);
    check_frame("even_rows", 24'h888111);
    idle(3);
    send_frame(2, 1'b1, 256);
    check_frame("even_rows_gaps", 24'h888111);
    check_busy_flag("even_rows_gaps");
    idle(2);
  endtask

  task automatic test_checker();
    send_frame(3, 1'b0, 256);
    check_frame("checker", 24'h888888);
    idle(10);
    checks++;
    if (FEAT !== 24'h888888) begin errors++; $display("FAIL checker_hold: got %h want 888888", FEAT); end
  endtask

  task automatic test_abort();
    int fv0;
    fv0 = fv_count;
    send_frame(3, 1'b0, 100);
    send_frame(0, 1'b0, 256);
    check_frame("abort", 24'h000000);
    check_busy_flag("abort");
    idle(2);
    checks++;
    if (fv_count - fv0 != 1) begin
      errors++;
      $display("FAIL abort_pulses: got %0d want 1", fv_count - fv0);
    end
  endtask

  task automatic test_clr_mid();
    int fv0;
    fv0 = fv_count;
    send_frame(3, 1'b0, 200);
    @(negedge CLK);
    CLR = 1'b1; PIX = 1'b1; SOF = 1'b1; PIX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0; SOF = 1'b0; PIX_VALID = 1'b0;
    checks++;
    if (FEAT !== 24'h0) begin errors++; $display("FAIL clr_feat: got %h want 000000", FEAT); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", BUSY); end
    for (int i = 0; i < 60; i++) px(1'b1, 1'b0, 1'b1);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL clr_needs_sof: got %b want 0", BUSY); end
    checks++;
    if (fv_count != fv0) begin errors++; $display("FAIL clr_no_fv: got %0d pulses want 0", fv_count - fv0); end
    busy_bad = 0;
    send_frame(1, 1'b0, 256);
    check_frame("clr_vbar", 24'h010111);
  endtask

  task automatic test_back_to_back();
    send_frame(1, 1'b0, 256);
    check_frame("b2b_first", 24'h010111);
    // Next SOF lands in the DONE cycle
    send_frame(3, 1'b0, 256);
    check_frame("b2b_second", 24'h888888);
    check_busy_flag("b2b");
    idle(2);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_zero_frame();
    test_vbar();
    test_even_rows();
    test_checker();
    test_abort();
    test_clr_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
